block_spawner: RTL and testbench
================================

// Module: block_spawner
// PURPOSE
//  Issues falling blocks. Drives the X-centre / ready / reset side of NUM_SLOTS block instances.
//  Each instance takes a centre X and a ready flag, and reports its Y.
//  A timer plus a 16-bit LFSR pick when a block drops and in which lane.
//  Blocks that fall off-screen are retired and their slot is recycled.
//  Sits between game control (enable) and the block instances feeding the colour mapper.
// PARAMETERS
//  NUM_SLOTS     4        block instances managed (2..8)
//  SPAWN_PERIOD  60       frames between launches (>=1)
//  LANE_X0       80       X centre of lane 0
//  LANE_PITCH    160      X distance between adjacent lanes (4 lanes, 0..3)
//  Y_MAX         479      block retired once its Y > Y_MAX
//  LFSR_SEED     16'hACE1 LFSR value after reset (must be nonzero)
// PORTS
//  frame_clk     in   1            frame clock; all state changes on its rising edge
//  Reset         in   1            synchronous, active-high
//  enable        in   1            1 = launching allowed; 0 = no new launches
//  block_y       in   10*NUM_SLOTS Y of slot k at [10k+9:10k]
//  block_x_center out 10*NUM_SLOTS X centre for slot k at [10k+9:10k], registered
//  block_ready   out  NUM_SLOTS    slot k may fall, registered
//  slot_reset    out  NUM_SLOTS    1-cycle pulse re-arming slot k, registered
//  spawn_count   out  8            launches since reset; wraps 255->0
// BEHAVIOUR
//  Reset values (one edge with Reset=1)
//  - state=IDLE, timer=0, active=0, block_ready=0, slot_reset=all ones, spawn_count=0.
//  - every block_x_center=LANE_X0, lfsr=LFSR_SEED, last_lane=3.
//  - slot_reset drops to 0 on the first edge after Reset deasserts.
//  LFSR: Fibonacci, taps 16,14,13,11. Shifts every non-reset edge in every state.
//  Retire, every state, every edge
//  - If active[k] and block_y[k] > Y_MAX: clear active[k] and block_ready[k].
//  - free[k] = ~active[k], taken from registered active.
//  - A slot retired on edge n is first selectable on edge n+1.
//  FSM
//  - IDLE:   enable=1 -> WAIT, timer=SPAWN_PERIOD-1.
//  - WAIT:   enable=0 -> IDLE; active blocks keep falling.
//            timer>0 -> timer-1.
//            timer==0 and any free slot -> PICK.
//            timer==0 and no free slot -> stay WAIT, timer held at 0 (stall).
//  - PICK:   slot = lowest-index free slot; lane = lfsr[1:0].
//            If lane==last_lane, lane=(lane+1) mod 4.
//            Write block_x_center[slot] = LANE_X0 + lane*LANE_PITCH (10-bit, no saturation).
//            last_lane = lane. -> LAUNCH.
//  - LAUNCH: slot_reset[slot]=1 for exactly this cycle; active[slot]=1; spawn_count+1.
//            -> WAIT, timer=SPAWN_PERIOD-1.
//            block_ready[slot]=1 from the next cycle until retired.
//  - enable falls in PICK or LAUNCH: that launch still completes, then go to IDLE.
//  Ordering guarantees
//  - block_x_center[slot] is stable >=1 cycle before and during slot_reset[slot].
//  - block_ready[slot] is 0 while slot_reset[slot]=1.
//  Latency: with enable sampled 1 on edge 0, the first slot_reset is high in the cycle after edge SPAWN_PERIOD+2.
//  Reset mid-operation (any state): all outputs return to reset values on that edge.
//  - Any in-progress launch is abandoned.
//  - slot_reset all-ones re-arms every downstream block.
// TESTING
//  1 Reset 2 cycles -> block_ready=0, slot_reset=4'hF, then 4'h0; all X=80; spawn_count=0.
//  2 SPAWN_PERIOD=4, enable=1 -> slot_reset=4'b0001 in the cycle after edge 6.
//    Its X matches the LFSR model; block_ready[0]=1 on the next cycle.
//  3 Force lfsr[1:0] equal to last_lane at PICK -> lane+1 used, e.g. last 3, lfsr 3 -> lane 0, X=80.
//  4 All 4 slots active, block_y all 100 -> FSM stalls in WAIT with timer=0, no slot_reset.
//    Then set block_y[2]=480 -> active[2] clears; slot 2 is relaunched 2 edges later.
//  5 Reset asserted while in LAUNCH -> no block_ready set, spawn_count=0, slot_reset=4'hF next cycle.
//  6 enable dropped in WAIT -> IDLE; no launches.
//    Active slots retire normally when Y > 479; spawn_count unchanged.

Source files
------------

// File: rtl/block_spawner.sv
// Launches falling blocks into free slots on a timer, picking lanes from an LFSR
// and recycling slots whose block has dropped below the screen.
module block_spawner #(
   parameter int          NUM_SLOTS    = 4,
   parameter int          SPAWN_PERIOD = 60,
   parameter int          LANE_X0      = 80,
   parameter int          LANE_PITCH   = 160,
   parameter int          Y_MAX        = 479,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                    frame_clk,
   input  logic                    Reset,
   input  logic                    enable,
   input  logic [10*NUM_SLOTS-1:0] block_y,
   output logic [10*NUM_SLOTS-1:0] block_x_center,
   output logic [NUM_SLOTS-1:0]    block_ready,
   output logic [NUM_SLOTS-1:0]    slot_reset,
   output logic [7:0]              spawn_count
);

   localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int TW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(SPAWN_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, WAIT, PICK, LAUNCH} state_t;

   state_t               state, state_next;
   logic [TW-1:0]        timer, timer_next;
   logic [NUM_SLOTS-1:0] active;
   logic [NUM_SLOTS-1:0] free_slots;
   logic                 any_free;
   logic [15:0]          lfsr;
   logic [1:0]           last_lane;
   logic [1:0]           lane;
   logic [9:0]           lane_x;
   logic [SW-1:0]        slot;
   logic [SW-1:0]        pick_slot;
   logic                 do_pick;
   logic                 do_launch;

   assign free_slots = ~active;
   assign any_free   = |free_slots;

   // Scanning downward leaves the lowest-index free slot as the winner.
   always_comb begin
      pick_slot = '0;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (free_slots[k]) pick_slot = SW'(k);
      end
   end

   // Never repeat the previous lane: bump by one (mod 4) on a collision.
   always_comb begin
      lane = lfsr[1:0];
      if (lane == last_lane) lane = lane + 2'd1;
      lane_x = 10'(LANE_X0 + int'(lane) * LANE_PITCH);
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   always_comb begin
      state_next = state;
      timer_next = timer;
      case (state)
         IDLE: begin
            if (enable) begin
               state_next = WAIT;
               timer_next = TIMER_LOAD;
            end
         end
         WAIT: begin
            if (!enable) state_next = IDLE;
            else if (timer != '0) timer_next = timer - 1'b1;
            else if (any_free) state_next = PICK;
         end
         PICK: state_next = LAUNCH;
         LAUNCH: begin
            state_next = enable ? WAIT : IDLE;
            timer_next = TIMER_LOAD;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      do_pick   = (state == PICK);
      do_launch = (state == LAUNCH);
   end

   // Retirement wins over the ready set, and the launch pulse is issued last.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         lfsr        <= LFSR_SEED;
         last_lane   <= 2'd3;
         slot        <= '0;
         active      <= '0;
         block_ready <= '0;
         slot_reset  <= '1;
         spawn_count <= '0;
         for (int k = 0; k < NUM_SLOTS; k++) block_x_center[10*k +: 10] <= 10'(LANE_X0);
      end else begin
         lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         slot_reset <= '0;
         if (do_pick) begin
            slot      <= pick_slot;
            last_lane <= lane;
            block_x_center[10*int'(pick_slot) +: 10] <= lane_x;
         end
         for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_reset[k] && active[k]) block_ready[k] <= 1'b1;
            if (active[k] && (block_y[10*k +: 10] > 10'(Y_MAX))) begin
               active[k]      <= 1'b0;
               block_ready[k] <= 1'b0;
            end
         end
         if (do_launch) begin
            slot_reset[slot] <= 1'b1;
            active[slot]     <= 1'b1;
            spawn_count      <= spawn_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_block_spawner.sv
// Directed bench for block_spawner: a cycle-level reference model predicts outputs and
// queues each expected launch (slot, X), checked when the DUT pulses slot_reset.
module tb_block_spawner;

   localparam int          NS   = 4;
   localparam int          P    = 4;
   // Chosen so the first ten feedback bits are all ones: the first pick sees lfsr[1:0]==3==last_lane.
   localparam logic [15:0] SEED = 16'h06B0;

   logic            frame_clk;
   logic            Reset;
   logic            enable;
   logic [10*NS-1:0] block_y;
   logic [10*NS-1:0] block_x_center;
   logic [NS-1:0]   block_ready;
   logic [NS-1:0]   slot_reset;
   logic [7:0]      spawn_count;

   int n_vec = 0;
   int n_err = 0;

   block_spawner #(
      .NUM_SLOTS   (NS),
      .SPAWN_PERIOD(P),
      .LANE_X0     (80),
      .LANE_PITCH  (160),
      .Y_MAX       (479),
      .LFSR_SEED   (SEED)
   ) dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .enable        (enable),
      .block_y       (block_y),
      .block_x_center(block_x_center),
      .block_ready   (block_ready),
      .slot_reset    (slot_reset),
      .spawn_count   (spawn_count)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   typedef struct packed {
      logic [1:0] slot;
      logic [9:0] x;
   } launch_t;

   launch_t exp_q[$];

   int          m_state;
   int          m_timer;
   int          m_slot;
   logic [NS-1:0] m_active;
   logic [NS-1:0] m_ready;
   logic [NS-1:0] m_sreset;
   logic [7:0]  m_count;
   logic [15:0] m_lfsr;
   logic [1:0]  m_last;

   // Reference model: 0=IDLE 1=WAIT 2=PICK 3=LAUNCH.
   always @(posedge frame_clk) begin : model
      logic [NS-1:0] nact;
      logic [NS-1:0] nrdy;
      logic [NS-1:0] nsr;
      logic [1:0]    ln;
      int            fs;
      launch_t       ent;
      if (Reset) begin
         m_state  <= 0;
         m_timer  <= 0;
         m_slot   <= 0;
         m_active <= '0;
         m_ready  <= '0;
         m_sreset <= '1;
         m_count  <= '0;
         m_lfsr   <= SEED;
         m_last   <= 2'd3;
         exp_q.delete();
      end else begin
         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         nact = m_active;
         nrdy = m_ready;
         nsr  = '0;
         for (int k = 0; k < NS; k++) begin
            if (m_sreset[k] && m_active[k]) nrdy[k] = 1'b1;
            if (m_active[k] && block_y[10*k +: 10] > 10'd479) begin
               nact[k] = 1'b0;
               nrdy[k] = 1'b0;
            end
         end
         case (m_state)
            0: if (enable) begin m_state <= 1; m_timer <= P - 1; end
            1: begin
               if (!enable) m_state <= 0;
               else if (m_timer > 0) m_timer <= m_timer - 1;
               else if (m_active != '1) m_state <= 2;
            end
            2: begin
               fs = 0;
               for (int k = NS - 1; k >= 0; k--) if (!m_active[k]) fs = k;
               ln = m_lfsr[1:0];
               if (ln == m_last) ln = ln + 2'd1;
               m_last   <= ln;
               m_slot   <= fs;
               ent.slot = fs[1:0];
               ent.x    = 10'(80 + int'(ln) * 160);
               exp_q.push_back(ent);
               m_state  <= 3;
            end
            default: begin
               nsr[m_slot]  = 1'b1;
               nact[m_slot] = 1'b1;
               m_count <= m_count + 8'd1;
               m_state <= enable ? 1 : 0;
               m_timer <= P - 1;
            end
         endcase
         m_active <= nact;
         m_ready  <= nrdy;
         m_sreset <= nsr;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en);
      Reset  = rst;
      enable = en;
   endtask

   task automatic setY(input int k, input logic [9:0] v);
      block_y[10*k +: 10] = v;
   endtask

   task automatic compareModel();
      launch_t e;
      checkOutput("ready", 32'(block_ready), 32'(m_ready));
      checkOutput("slot_reset", 32'(slot_reset), 32'(m_sreset));
      checkOutput("count", 32'(spawn_count), 32'(m_count));
      if ($onehot(slot_reset)) begin
         checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("launch_slot", 32'(slot_reset), 32'(1 << e.slot));
            checkOutput("launch_x", 32'(block_x_center[10*int'(e.slot) +: 10]), 32'(e.x));
         end
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
      compareModel();
   endtask

   task automatic waitCount(input string tag, input int budget, input logic [7:0] target);
      int n = 0;
      while (spawn_count != target && n < budget) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(spawn_count), 32'(target));
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < NS; k++) setY(k, 10'd100);

      // Reset
      tick();
      tick();
      checkOutput("reset_ready", 32'(block_ready), 32'h0);
      checkOutput("reset_slot_reset", 32'(slot_reset), 32'hF);
      checkOutput("reset_count", 32'(spawn_count), 32'h0);
      for (int k = 0; k < NS; k++) checkOutput("reset_x", 32'(block_x_center[10*k +: 10]), 32'd80);
      applyStimulus(1'b0, 1'b0);
      tick();
      checkOutput("slot_reset_release", 32'(slot_reset), 32'h0);

      // First launch latency and lane-collision bump (last 3, lfsr 3 -> lane 0)
      applyStimulus(1'b0, 1'b1);
      for (int e = 0; e < 6; e++) begin
         tick();
         checkOutput("latency_quiet", 32'(slot_reset), 32'h0);
      end
      tick();
      checkOutput("first_launch", 32'(slot_reset), 32'h1);
      checkOutput("collision_x", 32'(block_x_center[9:0]), 32'd80);
      checkOutput("ready_during_pulse", 32'(block_ready[0]), 32'd0);
      tick();
      checkOutput("first_ready", 32'(block_ready[0]), 32'd1);

      // Fill all slots, then stall
      waitCount("fill_slots", 60, 8'd4);
      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput("stall_quiet", 32'(slot_reset), 32'h0);
      end
      checkOutput("stall_count", 32'(spawn_count), 32'd4);

      // Retire slot 2 and watch it relaunch
      setY(2, 10'd480);
      tick();
      checkOutput("retire_ready2", 32'(block_ready[2]), 32'd0);
      setY(2, 10'd100);
      begin
         int n = 0;
         while (slot_reset != 4'b0100 && n < 6) begin
            tick();
            n++;
         end
         checkOutput("relaunch_slot2", 32'(slot_reset), 32'h4);
      end
      checkOutput("relaunch_count", 32'(spawn_count), 32'd5);

      // Reset while in LAUNCH
      setY(3, 10'd480);
      tick();
      setY(3, 10'd100);
      begin
         int n = 0;
         while (m_state != 3 && n < 10) begin
            tick();
            n++;
         end
         checkOutput("reach_launch", 32'(m_state), 32'd3);
      end
      applyStimulus(1'b1, 1'b1);
      tick();
      checkOutput("midreset_ready", 32'(block_ready), 32'h0);
      checkOutput("midreset_count", 32'(spawn_count), 32'h0);
      checkOutput("midreset_slot_reset", 32'(slot_reset), 32'hF);
      applyStimulus(1'b0, 1'b1);
      tick();
      checkOutput("midreset_release", 32'(slot_reset), 32'h0);

      // Drop enable in WAIT: no further launches, retirement continues
      waitCount("relaunch_two", 40, 8'd2);
      begin
         int n = 0;
         while (!(m_state == 1 && m_timer > 0) && n < 10) begin
            tick();
            n++;
         end
         checkOutput("reach_wait", 32'(m_state), 32'd1);
      end
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput("disabled_quiet", 32'(slot_reset), 32'h0);
      end
      checkOutput("disabled_count", 32'(spawn_count), 32'd2);
      checkOutput("disabled_ready", 32'(block_ready), 32'h3);
      setY(0, 10'd480);
      tick();
      checkOutput("disabled_retire0", 32'(block_ready), 32'h2);
      checkOutput("disabled_count_after", 32'(spawn_count), 32'd2);
      setY(0, 10'd100);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
